// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_pkg
// Description : Shared types and constants for the four-way round-robin
//               arbiter: FSM state encoding, requester count, index width.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/decoder2to4.sv
`default_nettype none
// ============================================================================
// Module      : Decoder2to4
// Description : 2-to-4 one-hot decoder with enable; all-zero output when
//               the enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module Decoder2to4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] dec
);

  // One-hot of sel, masked by the enable
  always_comb begin
    dec = 4'b0000;
    if (en) dec[sel] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational rotated-priority search. Scans req starting at
//               ptr and wrapping modulo 4; the first set bit wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
  import rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [ID_W-1:0]  win_id,
  output logic             win_valid
);

  logic [ID_W-1:0] idx;
  logic            found;

  // Walk ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap) and keep the first hit
  always_comb begin
    win_id = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!found && req[idx]) begin
        win_id = idx;
        found  = 1'b1;
      end
    end
    win_valid = en && found;
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-requester round-robin arbiter with a per-ownership hold
//               limit. Registers the owner index and valid flag; the one-hot
//               grant is decoded from those registers, so there is no
//               combinational path from req to gnt.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4
  import rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             expired
);

  // Last hold_cnt value before a forced release (unused when MAX_HOLD is 0)
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state, state_next;
  logic [ID_W-1:0]   ptr, ptr_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [ID_W-1:0]   id_next;
  logic              valid_next;
  logic              expired_next;

  logic [ID_W-1:0]   win_id;
  logic              win_valid;
  logic              owner_req;
  logic              limit_hit;

  rr_pick4 u_pick (
    .req       (req),
    .ptr       (ptr),
    .en        (en),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  Decoder2to4 u_dec (
    .sel (gnt_id),
    .en  (gnt_valid),
    .dec (gnt)
  );

  assign owner_req = req[gnt_id];
  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  // State, pointer, hold counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      hold_cnt  <= hold_next;
      gnt_id    <= id_next;
      gnt_valid <= valid_next;
      expired   <= expired_next;
    end
  end

  // Next-state logic: grant from IDLE, hold or release from OWNED
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    hold_next    = hold_cnt;
    id_next      = gnt_id;
    valid_next   = gnt_valid;
    expired_next = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          id_next    = win_id;
          valid_next = 1'b1;
          hold_next  = '0;
          state_next = OWNED;
        end
      end
      OWNED: begin
        if (!owner_req || limit_hit) begin
          // A dropped request takes precedence, so expired only fires when
          // the owner was still requesting at the limit.
          valid_next   = 1'b0;
          ptr_next     = gnt_id + ID_W'(1);
          state_next   = IDLE;
          expired_next = owner_req;
        end else if (hold_cnt != '1) begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter4
// Description : Directed self-checking bench for rr_arbiter4. Two instances
//               share all inputs: dut_a (MAX_HOLD=4) and dut_b (MAX_HOLD=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       valid_a, valid_b, exp_a, exp_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(4), .HOLD_W(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .req(req),
    .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(valid_a), .expired(exp_a)
  );

  rr_arbiter4 #(.MAX_HOLD(3), .HOLD_W(8)) dut_b (
    .clk(clk), .reset(reset), .en(en), .req(req),
    .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(valid_b), .expired(exp_b)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       expd;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic r, logic e, logic [3:0] q,
                              logic [3:0] g, logic [1:0] i, logic v, logic x);
    vec_t t;
    t.rst = r; t.en = e; t.req = q; t.gnt = g; t.id = i; t.valid = v; t.expd = x;
    return t;
  endfunction

  // One rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {gnt,id,valid,exp}=%b required %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pk(logic [3:0] g, logic [1:0] i, logic v, logic x);
    return {g, i, v, x};
  endfunction

  int exp_pulses;

  initial begin
    // Owner sequence: single request, ptr effect, fairness, en gating, reset
    vecs[0]  = mk(1, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);
    vecs[1]  = mk(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);
    vecs[2]  = mk(0, 1, 4'b0100, 4'b0100, 2'd2, 1, 0);
    vecs[3]  = mk(0, 1, 4'b0100, 4'b0100, 2'd2, 1, 0);
    vecs[4]  = mk(0, 1, 4'b0000, 4'b0000, 2'd2, 0, 0);
    vecs[5]  = mk(0, 1, 4'b1001, 4'b1000, 2'd3, 1, 0);
    vecs[6]  = mk(0, 1, 4'b0000, 4'b0000, 2'd3, 0, 0);
    vecs[7]  = mk(0, 1, 4'b0011, 4'b0001, 2'd0, 1, 0);
    vecs[8]  = mk(0, 1, 4'b0010, 4'b0000, 2'd0, 0, 0);
    vecs[9]  = mk(0, 1, 4'b0010, 4'b0010, 2'd1, 1, 0);
    vecs[10] = mk(0, 1, 4'b0011, 4'b0010, 2'd1, 1, 0);
    vecs[11] = mk(0, 1, 4'b0001, 4'b0000, 2'd1, 0, 0);
    vecs[12] = mk(0, 1, 4'b0011, 4'b0001, 2'd0, 1, 0);
    vecs[13] = mk(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);
    vecs[14] = mk(0, 0, 4'b0010, 4'b0000, 2'd0, 0, 0);
    vecs[15] = mk(0, 0, 4'b0010, 4'b0000, 2'd0, 0, 0);
    vecs[16] = mk(0, 1, 4'b0010, 4'b0010, 2'd1, 1, 0);
    vecs[17] = mk(0, 0, 4'b0010, 4'b0010, 2'd1, 1, 0);
    vecs[18] = mk(0, 0, 4'b0000, 4'b0000, 2'd1, 0, 0);
    vecs[19] = mk(0, 1, 4'b0000, 4'b0000, 2'd1, 0, 0);
    vecs[20] = mk(0, 1, 4'b1000, 4'b1000, 2'd3, 1, 0);
    vecs[21] = mk(1, 1, 4'b1000, 4'b0000, 2'd0, 0, 0);
    vecs[22] = mk(0, 1, 4'b1001, 4'b0001, 2'd0, 1, 0);
    vecs[23] = mk(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);

    reset = 1'b1; en = 1'b1; req = 4'b0000;
    #2;

    for (int k = 0; k < 24; k++) begin
      reset = vecs[k].rst;
      en    = vecs[k].en;
      req   = vecs[k].req;
      step();
      check($sformatf("vec%0d", k), pk(gnt_a, id_a, valid_a, exp_a),
            pk(vecs[k].gnt, vecs[k].id, vecs[k].valid, vecs[k].expd));
    end

    // Rotation under full load, MAX_HOLD=4: owners 0,1,2,3,0
    reset = 1'b1; req = 4'b0000; en = 1'b1;
    step();
    reset = 1'b0; req = 4'b1111;
    exp_pulses = 0;
    for (int o = 0; o < 5; o++) begin
      logic [1:0] oid;
      logic [3:0] oh;
      oid = 2'(o % 4);
      oh  = 4'b0001 << oid;
      for (int c = 0; c < 4; c++) begin
        step();
        check($sformatf("rot_own%0d_c%0d", o, c), pk(gnt_a, id_a, valid_a, exp_a),
              pk(oh, oid, 1'b1, 1'b0));
      end
      step();
      if (exp_a) exp_pulses++;
      check($sformatf("rot_gap%0d", o), pk(gnt_a, id_a, valid_a, exp_a),
            pk(4'b0000, oid, 1'b0, 1'b1));
    end
    checks++;
    if (exp_pulses != 5) begin
      failures++;
      $display("FAIL rot_pulses: got %0d required 5", exp_pulses);
    end
    req = 4'b0000;
    step();
    step();

    // Timeout versus drop on dut_b (MAX_HOLD=3)
    reset = 1'b1;
    step();
    reset = 1'b0; req = 4'b0001;
    step();
    check("tod_grant1", pk(gnt_b, id_b, valid_b, exp_b), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    step();
    check("tod_hold1", pk(gnt_b, id_b, valid_b, exp_b), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    step();
    check("tod_hold2", pk(gnt_b, id_b, valid_b, exp_b), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    req = 4'b0000;
    step();
    check("tod_drop", pk(gnt_b, id_b, valid_b, exp_b), pk(4'b0000, 2'd0, 1'b0, 1'b0));
    req = 4'b0001;
    step();
    check("tod_grant2", pk(gnt_b, id_b, valid_b, exp_b), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    step();
    step();
    check("tod_hold3", pk(gnt_b, id_b, valid_b, exp_b), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    step();
    check("tod_timeout", pk(gnt_b, id_b, valid_b, exp_b), pk(4'b0000, 2'd0, 1'b0, 1'b1));
    step();
    check("tod_regrant", pk(gnt_b, id_b, valid_b, exp_b), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    req = 4'b0000;
    step();
    check("tod_release", pk(gnt_b, id_b, valid_b, exp_b), pk(4'b0000, 2'd0, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one resource, such as a bus slot, register-file write port or memory port, among four masters. It registers a one-hot grant vector and a 2-bit owner index. The owner keeps the grant until it drops its request or exceeds a hold limit. Priority then rotates to the requester after the last owner, so no master starves.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum consecutive grant cycles per ownership; 0 = unlimited.
- HOLD_W, default 8: width of hold counter; MAX_HOLD < 2^HOLD_W.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on clk rising edge.
- en  in  1  arbitration enable (positive logic); 0 blocks new grants only.
- req  in  4  request per master, level-sensitive, held while using resource.
- gnt  out  4  one-hot grant, registered; all-zero when idle.
- gnt_id  out  2  index of current owner; valid only when gnt_valid=1.
- gnt_valid  out  1  OR of gnt, registered.
- expired  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Reset values: gnt=4'b0000, gnt_id=2'd0, gnt_valid=0, expired=0, ptr=2'd0, hold_cnt=0, state IDLE.
- State machine has two states, IDLE and OWNED.
- IDLE with en=1 and req≠0: select the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). Register gnt_id=winner, gnt=one-hot(winner), hold_cnt=0, and go to OWNED.
- IDLE with en=0 or req=0: remain idle with outputs unchanged at zero.
- OWNED, normal release: req[gnt_id]=0 → gnt=0, gnt_valid=0, ptr=gnt_id+1 (mod 4, 3 wraps to 0), go to IDLE.
- OWNED, hold: req[gnt_id]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD-1) → hold_cnt+1 and grant kept. hold_cnt saturates at 2^HOLD_W-1 when MAX_HOLD=0.
- OWNED, timeout: req[gnt_id]=1 and hold_cnt=MAX_HOLD-1 → release exactly as normal release, plus expired=1 for one cycle.
- Simultaneous req drop and timeout on the same cycle: normal release, expired stays 0.
- Requests from non-owners during OWNED are ignored. They are arbitrated only in the following IDLE cycle.
- The en input does not affect an existing grant.
- Changes to req bits of non-owners are legal at any time; there is no latching of requests.
- Reset asserted mid-grant: outputs return to reset values at that edge, with no expired pulse.

## Timing
- Grant latency is 1 cycle. A req sampled at edge k in IDLE produces gnt valid after edge k.
- Release latency is 1 cycle. A req drop sampled at edge k produces gnt=0 after edge k.
- There is always exactly one IDLE cycle (dead cycle) between consecutive owners. Minimum turnaround is 2 cycles.
- A single owner holding continuously keeps the grant for exactly MAX_HOLD cycles (gnt high after edges k..k+MAX_HOLD-1). gnt drops and expired pulses after edge k+MAX_HOLD.
- All outputs are registered, with no combinational path from req to gnt.

## Structure
- Package rr_arbiter_pkg holds:
  - the state encoding (IDLE=1'b0, OWNED=1'b1);
  - the number of requesters, N_REQ=4;
  - the index width, ID_W=2.
- Sub-module rr_pick4 is combinational. Inputs are req[3:0], ptr[1:0] and en; outputs are win_id[1:0] and win_valid. It implements the rotated priority search.
- The one-hot grant is derived from the registered gnt_id through the existing Decoder2to4, with en=gnt_valid.
- The top level holds only the FSM, ptr, hold_cnt and the output registers.

## Test plan
- Reset then single request: req=4'b0100 from cycle 2 → gnt=4'b0100, gnt_id=2 after the next edge. Drop req → gnt=0 one edge later, ptr=3.
- Rotation: req=4'b1111 held, MAX_HOLD=4 → owners 0,1,2,3,0 in order. Each holds 4 cycles with one idle cycle between owners. expired pulses 5 times.
- Fairness after release: owner 1 releases while req=4'b0011 → next owner is 0 only after ptr wraps. With ptr=2, search order 2,3,0 selects 0.
- Timeout vs drop: MAX_HOLD=3, owner drops req exactly on its 3rd grant cycle → release, expired=0. Same run without the drop → expired=1.
- en gating: en=0 with req=4'b0010 → gnt stays 0. Set en=1 → grant 1 cycle later. Set en=0 during ownership → grant retained.
- Reset mid-grant: reset=1 while gnt=4'b1000 → all outputs zero, ptr=0 after that edge. Then req=4'b1001 → grant to 0.
